// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered, lockable one-hot grant; priority rotates to just above the last winner.
// Optional owner hold limit is compiled in with `define RR_ARB_TIMEOUT_EN (limit set by HOLD_MAX).
module rr_arbiter #(
    parameter int REQ_N    = 4,
    parameter int ID_W     = $clog2(REQ_N),
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_N-1:0] req,
    output logic [REQ_N-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_vld
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [REQ_N-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic             gnt_vld_q, gnt_vld_d;

    logic [REQ_N-1:0] cand;
    logic [REQ_N-1:0] above_last;
    logic [REQ_N-1:0] cand_masked;
    logic [REQ_N-1:0] search_vec;
    logic [REQ_N-1:0] win_oh;
    logic [ID_W-1:0]  win_id;
    logic             owner_req;
    logic             cand_any;
    logic             hold_expired;
    logic             new_grant;

    if (REQ_N < 2 || HOLD_MAX < 1) begin : g_param_check
        $error("rr_arbiter: REQ_N must be >= 2 and HOLD_MAX >= 1");
    end

    function automatic logic [REQ_N-1:0] isolate_lsb(input logic [REQ_N-1:0] v);
        return v & (~v + REQ_N'(1));
    endfunction

    function automatic logic [ID_W-1:0] onehot_to_id(input logic [REQ_N-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (oh[i]) begin
                id = id | ID_W'(i);
            end
        end
        return id;
    endfunction

    // The current owner is never a candidate; in IDLE gnt_q is zero so this is just req.
    assign cand = req & ~gnt_q;

    genvar gi;
    generate
        for (gi = 0; gi < REQ_N; gi++) begin : g_mask
            assign above_last[gi] = (ID_W'(gi) > last_q);
        end
    endgenerate

    assign cand_masked = cand & above_last;
    assign search_vec  = (|cand_masked) ? cand_masked : cand;
    assign win_oh      = isolate_lsb(search_vec);
    assign win_id      = onehot_to_id(win_oh);
    assign owner_req   = |(req & gnt_q);
    assign cand_any    = |cand;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hold_expired = (cnt_q == CNT_LAST);

    // Saturates at the limit so a lone owner keeps the grant without wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = '0;
        end else if (state_q == GRANT && !hold_expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign hold_expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        gnt_vld_d = gnt_vld_q;
        new_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (owner_req && !(hold_expired && cand_any)) begin
                    state_d = GRANT;
                end else if (cand_any) begin
                    new_grant = 1'b1;
                end else begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    gnt_vld_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_id_d  = '0;
                gnt_vld_d = 1'b0;
            end
        endcase

        if (new_grant) begin
            state_d   = GRANT;
            gnt_d     = win_oh;
            gnt_id_d  = win_id;
            last_d    = win_id;
            gnt_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            last_q    <= ID_W'(REQ_N - 1);
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_q    <= last_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;

endmodule
